// File: rtl/ocx_tlx_fifo_rd_pkg.sv
// Shared types and helpers for the TLX FIFO read stage and its credit batcher.
package ocx_tlx_fifo_rd_pkg;

    // Credit return FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCUM  = 2'b01,
        RETURN = 2'b10
    } credit_state_e;

    // Credit counters must hold 2^FIFO_ADDR_WIDTH, hence one extra bit
    function automatic int unsigned credit_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/ocx_tlx_credit_batcher.sv
// Accumulates one credit per FIFO pop and returns batches upstream on a
// valid/ack handshake, either when a full batch is collected or after an
// idle timeout with a partial batch.
module ocx_tlx_credit_batcher
    import ocx_tlx_fifo_rd_pkg::*;
#(
    parameter int unsigned FIFO_ADDR_WIDTH = 4,
    parameter int unsigned CREDIT_BATCH    = 4,
    parameter int unsigned CREDIT_TIMEOUT  = 8
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    pop,
    input  logic                                    ack,
    output logic                                    credit_return_valid,
    output logic [credit_width(FIFO_ADDR_WIDTH)-1:0] credit_return_cnt
);

    localparam int unsigned CW = credit_width(FIFO_ADDR_WIDTH);
    localparam int unsigned TW = $clog2(CREDIT_TIMEOUT) + 1;

    credit_state_e   state_q;
    logic [CW-1:0]   accum_q;
    logic [CW-1:0]   cnt_q;
    logic            valid_q;
    logic [TW-1:0]   timer_q;

    logic [CW-1:0]   accum_d;
    logic            batch_full;
    logic            timed_out;

    // Running credit total including a pop in the current cycle
    assign accum_d    = accum_q + CW'(pop);
    assign batch_full = (32'(accum_d) >= CREDIT_BATCH);
    // Timer value after this idle cycle reaching CREDIT_TIMEOUT-1 releases a partial batch
    assign timed_out  = !pop && ((32'(timer_q) + 32'd1) >= (CREDIT_TIMEOUT - 32'd1));

    // Credit FSM with accumulator, idle timer and registered return outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            accum_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            timer_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    accum_q <= accum_d;
                    timer_q <= '0;
                    if (pop) begin
                        if (batch_full) begin
                            state_q <= RETURN;
                            cnt_q   <= accum_d;
                            accum_q <= '0;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (batch_full || timed_out) begin
                        state_q <= RETURN;
                        cnt_q   <= accum_d;
                        accum_q <= '0;
                        valid_q <= 1'b1;
                        timer_q <= '0;
                    end else begin
                        accum_q <= accum_d;
                        timer_q <= pop ? '0 : timer_q + TW'(1);
                    end
                end
                RETURN: begin
                    // Batch is frozen until ack; new pops keep accumulating
                    accum_q <= accum_d;
                    if (ack) begin
                        valid_q <= 1'b0;
                        timer_q <= '0;
                        state_q <= (accum_d != '0) ? ACCUM : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign credit_return_valid = valid_q;
    assign credit_return_cnt   = cnt_q;

endmodule

// File: rtl/ocx_tlx_fifo_rd_stage.sv
// TLX FIFO read-side stage: pops the FIFO head into a registered 2-entry
// valid/ready output buffer and batches one credit per pop for return upstream.
// Optional per-byte even-parity checking on popped entries is enabled by
// defining OCX_TLX_FIFO_RD_PARITY_EN.
module ocx_tlx_fifo_rd_stage
    import ocx_tlx_fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned FIFO_ADDR_WIDTH = 4,
    parameter int unsigned CREDIT_BATCH    = 4,
    parameter int unsigned CREDIT_TIMEOUT  = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      fifo_data_available,
    input  logic [DATA_WIDTH-1:0]     ram_rd_data,
`ifdef OCX_TLX_FIFO_RD_PARITY_EN
    input  logic [DATA_WIDTH/8-1:0]   ram_rd_par,
    output logic                      parity_err,
`endif
    output logic                      fifo_rd_done,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    input  logic                      out_ready,
    output logic                      credit_return_valid,
    output logic [FIFO_ADDR_WIDTH:0]  credit_return_cnt,
    input  logic                      credit_return_ack
);

    localparam int unsigned CW = credit_width(FIFO_ADDR_WIDTH);

    logic [1:0]            buf_cnt_q;
    logic [1:0]            buf_cnt_d;
    logic [DATA_WIDTH-1:0] slot0_q;
    logic [DATA_WIDTH-1:0] slot1_q;
    logic [DATA_WIDTH-1:0] slot0_d;
    logic [DATA_WIDTH-1:0] slot1_d;
    logic                  out_valid_q;
    logic                  pop;
    logic                  drain;
    logic [CW-1:0]         credit_cnt;

    // Pop depends only on registered occupancy so out_ready never reaches fifo_rd_done
    assign pop   = fifo_data_available && (buf_cnt_q < 2'd2);
    assign drain = out_valid_q && out_ready;

    // Output buffer next state; slot 0 is always the head
    always_comb begin
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        buf_cnt_d = buf_cnt_q;
        case ({pop, drain})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    slot0_d = ram_rd_data;
                end else begin
                    slot1_d = ram_rd_data;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                slot0_d   = slot1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with one entry held: head leaves, new entry becomes head
                slot0_d = ram_rd_data;
            end
            default: begin
            end
        endcase
    end

    // Output buffer registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            buf_cnt_q   <= 2'd0;
            slot0_q     <= '0;
            slot1_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            buf_cnt_q   <= buf_cnt_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            out_valid_q <= (buf_cnt_d != 2'd0);
        end
    end

    assign fifo_rd_done = pop;
    assign out_valid    = out_valid_q;
    assign out_data     = slot0_q;

    ocx_tlx_credit_batcher #(
        .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH),
        .CREDIT_BATCH    (CREDIT_BATCH),
        .CREDIT_TIMEOUT  (CREDIT_TIMEOUT)
    ) u_credit_batcher (
        .clock               (clock),
        .reset_n             (reset_n),
        .pop                 (pop),
        .ack                 (credit_return_ack),
        .credit_return_valid (credit_return_valid),
        .credit_return_cnt   (credit_cnt)
    );

    assign credit_return_cnt = credit_cnt;

`ifdef OCX_TLX_FIFO_RD_PARITY_EN
    logic par_mismatch;
    logic parity_err_q;

    // Any byte whose parity bit does not make the byte+bit even flags the entry
    always_comb begin
        par_mismatch = 1'b0;
        for (int i = 0; i < int'(DATA_WIDTH / 8); i++) begin
            if ((^ram_rd_data[i*8 +: 8]) != ram_rd_par[i]) begin
                par_mismatch = 1'b1;
            end
        end
    end

    // Sticky error flag, set by a bad entry on pop
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_q | (pop & par_mismatch);
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_ocx_tlx_fifo_rd_stage.sv
// Directed self-checking bench for ocx_tlx_fifo_rd_stage (default parameters).
module tb_ocx_tlx_fifo_rd_stage;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 4;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            fifo_data_available;
    logic [DW-1:0]   ram_rd_data;
    logic            fifo_rd_done;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic            credit_return_valid;
    logic [AW:0]     credit_return_cnt;
    logic            credit_return_ack;
`ifdef OCX_TLX_FIFO_RD_PARITY_EN
    logic [DW/8-1:0] ram_rd_par;
    logic            parity_err;
    logic [DW/8-1:0] par_flip;
`endif

    int passed = 0;
    int total  = 0;
    logic auto_ack = 1'b0;

    always #5 clock = ~clock;

    ocx_tlx_fifo_rd_stage #(
        .DATA_WIDTH      (DW),
        .FIFO_ADDR_WIDTH (AW),
        .CREDIT_BATCH    (4),
        .CREDIT_TIMEOUT  (8)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .fifo_data_available (fifo_data_available),
        .ram_rd_data         (ram_rd_data),
`ifdef OCX_TLX_FIFO_RD_PARITY_EN
        .ram_rd_par          (ram_rd_par),
        .parity_err          (parity_err),
`endif
        .fifo_rd_done        (fifo_rd_done),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .out_ready           (out_ready),
        .credit_return_valid (credit_return_valid),
        .credit_return_cnt   (credit_return_cnt),
        .credit_return_ack   (credit_return_ack)
    );

`ifdef OCX_TLX_FIFO_RD_PARITY_EN
    function automatic logic [DW/8-1:0] par_of(input logic [DW-1:0] d);
        logic [DW/8-1:0] p;
        for (int i = 0; i < int'(DW / 8); i++) p[i] = ^d[i*8 +: 8];
        return p;
    endfunction
    assign ram_rd_par = par_of(ram_rd_data) ^ par_flip;
`endif

    // Advance one cycle; optionally ack any presented credit batch this cycle
    task automatic step();
        @(posedge clock);
        #1;
        credit_return_ack = auto_ack && credit_return_valid;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        fifo_data_available = 1'b0;
        ram_rd_data = '0;
        out_ready = 1'b0;
        credit_return_ack = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        #1;
        total++; if (fifo_rd_done !== 1'b0) $display("FAIL reset_rd_done got=%b exp=0", fifo_rd_done); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL reset_out_data got=%0h exp=0", out_data); else passed++;
        total++; if (credit_return_valid !== 1'b0) $display("FAIL reset_crv got=%b exp=0", credit_return_valid); else passed++;
        total++; if (credit_return_cnt !== '0) $display("FAIL reset_cnt got=%0d exp=0", credit_return_cnt); else passed++;
    endtask

    task automatic test_stream();
        logic exp_crv;
        auto_ack = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            fifo_data_available = (i < 8);
            ram_rd_data = DW'(i);
            #1;
            total++; if (fifo_rd_done !== (i < 8)) $display("FAIL stream_rd_done cyc=%0d got=%b exp=%b", i, fifo_rd_done, (i < 8)); else passed++;
            if (i >= 1 && i <= 8) begin
                total++; if (out_valid !== 1'b1) $display("FAIL stream_valid cyc=%0d got=%b exp=1", i, out_valid); else passed++;
                total++; if (out_data !== DW'(i - 1)) $display("FAIL stream_data cyc=%0d got=%0h exp=%0h", i, out_data, i - 1); else passed++;
            end else begin
                total++; if (out_valid !== 1'b0) $display("FAIL stream_valid_idle cyc=%0d got=%b exp=0", i, out_valid); else passed++;
            end
            exp_crv = (i == 4) || (i == 8);
            total++; if (credit_return_valid !== exp_crv) $display("FAIL stream_crv cyc=%0d got=%b exp=%b", i, credit_return_valid, exp_crv); else passed++;
            if (exp_crv) begin
                total++; if (credit_return_cnt !== 5'd4) $display("FAIL stream_cnt cyc=%0d got=%0d exp=4", i, credit_return_cnt); else passed++;
            end
        end
        fifo_data_available = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx;
        logic exp_done;
        logic exp_v;
        logic [DW-1:0] exp_d;
        idx = 0;
        auto_ack = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            fifo_data_available = (i < 8);
            out_ready = (i == 5) || (i >= 8);
            ram_rd_data = DW'(100 + idx);
            #1;
            exp_done = (i == 0) || (i == 1) || (i == 6);
            total++; if (fifo_rd_done !== exp_done) $display("FAIL bp_rd_done cyc=%0d got=%b exp=%b", i, fifo_rd_done, exp_done); else passed++;
            if (fifo_rd_done) idx++;
            exp_v = 1'b1;
            exp_d = '0;
            if (i == 0 || i == 10) exp_v = 1'b0;
            else if (i <= 5) exp_d = DW'(100);
            else if (i <= 8) exp_d = DW'(101);
            else exp_d = DW'(102);
            total++; if (out_valid !== exp_v) $display("FAIL bp_valid cyc=%0d got=%b exp=%b", i, out_valid, exp_v); else passed++;
            if (exp_v) begin
                total++; if (out_data !== exp_d) $display("FAIL bp_data cyc=%0d got=%0h exp=%0h", i, out_data, exp_d); else passed++;
            end
        end
        fifo_data_available = 1'b0;
        out_ready = 1'b1;
        repeat (16) step();
        total++; if (credit_return_valid !== 1'b0) $display("FAIL bp_flush_crv got=%b exp=0", credit_return_valid); else passed++;
    endtask

    task automatic test_timeout();
        auto_ack = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            credit_return_ack = (i == 10);
            fifo_data_available = (i < 3);
            ram_rd_data = DW'(200 + i);
            #1;
            if (i < 10 || i == 11) begin
                total++; if (credit_return_valid !== 1'b0) $display("FAIL timeout_crv_low cyc=%0d got=%b exp=0", i, credit_return_valid); else passed++;
            end else begin
                total++; if (credit_return_valid !== 1'b1) $display("FAIL timeout_crv_high cyc=%0d got=%b exp=1", i, credit_return_valid); else passed++;
                total++; if (credit_return_cnt !== 5'd3) $display("FAIL timeout_cnt cyc=%0d got=%0d exp=3", i, credit_return_cnt); else passed++;
            end
        end
        fifo_data_available = 1'b0;
        credit_return_ack = 1'b0;
    endtask

    task automatic test_ack_stall();
        auto_ack = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step();
            credit_return_ack = (i == 14) || (i == 16);
            fifo_data_available = (i < 9);
            ram_rd_data = DW'(300 + i);
            #1;
            total++; if (fifo_rd_done !== (i < 9)) $display("FAIL stall_rd_done cyc=%0d got=%b exp=%b", i, fifo_rd_done, (i < 9)); else passed++;
            if (i < 4 || i == 15 || i == 17) begin
                total++; if (credit_return_valid !== 1'b0) $display("FAIL stall_crv_low cyc=%0d got=%b exp=0", i, credit_return_valid); else passed++;
            end else if (i <= 14) begin
                total++; if (credit_return_valid !== 1'b1) $display("FAIL stall_crv_hold cyc=%0d got=%b exp=1", i, credit_return_valid); else passed++;
                total++; if (credit_return_cnt !== 5'd4) $display("FAIL stall_cnt_hold cyc=%0d got=%0d exp=4", i, credit_return_cnt); else passed++;
            end else begin
                total++; if (credit_return_valid !== 1'b1) $display("FAIL stall_crv_second cyc=%0d got=%b exp=1", i, credit_return_valid); else passed++;
                total++; if (credit_return_cnt !== 5'd5) $display("FAIL stall_cnt_second cyc=%0d got=%0d exp=5", i, credit_return_cnt); else passed++;
            end
        end
        fifo_data_available = 1'b0;
        credit_return_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        int crv_seen;
        int ov_seen;
        auto_ack = 1'b0;
        credit_return_ack = 1'b0;
        // Cycle 0: pop A; cycle 1: pop B while A drains; cycle 2: pop C, buffer full, 3 credits held
        step(); fifo_data_available = 1'b1; out_ready = 1'b1; ram_rd_data = DW'(400);
        step(); ram_rd_data = DW'(401);
        step(); out_ready = 1'b0; ram_rd_data = DW'(402);
        step(); reset_n = 1'b0; ram_rd_data = DW'(403);
        #1;
        total++; if (fifo_rd_done !== 1'b0) $display("FAIL mid_full_block got=%b exp=0", fifo_rd_done); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got=%b exp=1", out_valid); else passed++;
        step(); reset_n = 1'b1; fifo_data_available = 1'b0;
        #1;
        total++; if (fifo_rd_done !== 1'b0) $display("FAIL mid_rd_done got=%b exp=0", fifo_rd_done); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL mid_out_data got=%0h exp=0", out_data); else passed++;
        total++; if (credit_return_valid !== 1'b0) $display("FAIL mid_crv got=%b exp=0", credit_return_valid); else passed++;
        total++; if (credit_return_cnt !== '0) $display("FAIL mid_cnt got=%0d exp=0", credit_return_cnt); else passed++;
        crv_seen = 0;
        ov_seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (credit_return_valid) crv_seen++;
            if (out_valid) ov_seen++;
        end
        total++; if (crv_seen !== 0) $display("FAIL mid_no_credits got=%0d exp=0", crv_seen); else passed++;
        total++; if (ov_seen !== 0) $display("FAIL mid_no_entries got=%0d exp=0", ov_seen); else passed++;
    endtask

`ifdef OCX_TLX_FIFO_RD_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        d0 = 64'h0123_4567_89AB_CDEF;
        d1 = 64'hFEDC_BA98_7654_3210;
        auto_ack = 1'b1;
        out_ready = 1'b1;
        step(); fifo_data_available = 1'b1; ram_rd_data = d0; par_flip = '0;
        step(); ram_rd_data = d1; par_flip = 8'h04;
        #1;
        total++; if (parity_err !== 1'b0) $display("FAIL par_clean got=%b exp=0", parity_err); else passed++;
        total++; if (out_data !== d0) $display("FAIL par_data0 got=%0h exp=%0h", out_data, d0); else passed++;
        step(); fifo_data_available = 1'b0; par_flip = '0;
        #1;
        total++; if (parity_err !== 1'b1) $display("FAIL par_set got=%b exp=1", parity_err); else passed++;
        total++; if (out_data !== d1) $display("FAIL par_data1 got=%0h exp=%0h", out_data, d1); else passed++;
        repeat (3) step();
        total++; if (parity_err !== 1'b1) $display("FAIL par_sticky got=%b exp=1", parity_err); else passed++;
        reset_n = 1'b0;
        step(); reset_n = 1'b1;
        #1;
        total++; if (parity_err !== 1'b0) $display("FAIL par_reset got=%b exp=0", parity_err); else passed++;
    endtask
`endif

    initial begin
`ifdef OCX_TLX_FIFO_RD_PARITY_EN
        par_flip = '0;
`endif
        test_reset();
        test_stream();
        test_backpressure();
        test_timeout();
        test_ack_stall();
        test_reset_mid();
`ifdef OCX_TLX_FIFO_RD_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
